lpc_sniffer: RTL and testbench

// - Passive LPC bus sniffer (DUT name: lpc). Watches LAD[3:0]/LFRAME# on the LPC clock and decodes memory and IO cycles.
// - Outputs cycle type/dir, address, data and size for each completed cycle, with a one-cycle strobe.
// - Sits between the LPC pins and a capture FIFO/UART that is enabled by the strobe. Never drives the bus.

---
 rtl/lpc_sniffer.sv | 217 +++++++++++++++++++++
 tb/tb_lpc_sniffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_sniffer.sv
`default_nettype none
// ============================================================================
// Module   : lpc_sniffer
// Purpose  : Passive LPC bus sniffer. Watches LAD[3:0]/LFRAME# on the LPC
//            clock, decodes memory (and optionally IO) cycles and presents
//            each completed cycle as one record with a one-cycle strobe.
//            The bus is never driven.
// Ports    : lpc_clock        in   LPC clock, rising-edge logic
//            lpc_reset        in   synchronous active-high reset
//            lpc_ad[3:0]      in   LAD nibble bus
//            lpc_frame        in   LFRAME#, active-low
//            out_cyctype_dir  out  {type[1:0], dir, 1'b0}
//            out_addr[31:0]   out  captured address (IO zero-extended)
//            out_data[31:0]   out  captured data, byte 0 in [7:0]
//            out_data_size    out  data byte count (1, 2 or 4)
//            out_clock_enable out  one-cycle strobe: new record valid
// Config   : LPC_IO_DECODE_EN defined   -> IO cycles decoded and reported
//            LPC_IO_DECODE_EN undefined -> memory cycles only
// Revision : 1.0 - initial release
// ============================================================================
module lpc_sniffer #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic [3:0]  lpc_ad,
  input  logic        lpc_frame,
  output logic [3:0]  out_cyctype_dir,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic [3:0]  out_data_size,
  output logic        out_clock_enable
);

`ifdef LPC_IO_DECODE_EN
  localparam bit c_io_en = 1'b1;
`else
  localparam bit c_io_en = 1'b0;
`endif

  localparam int unsigned c_wait_w = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(WAIT_LIMIT);

  // TAR1 precedes SYNC, TAR2 is the final turnaround before DONE.
  localparam logic [3:0] c_st_idle  = 4'd0;
  localparam logic [3:0] c_st_ctdir = 4'd1;
  localparam logic [3:0] c_st_size  = 4'd2;
  localparam logic [3:0] c_st_addr  = 4'd3;
  localparam logic [3:0] c_st_data  = 4'd4;
  localparam logic [3:0] c_st_tar1  = 4'd5;
  localparam logic [3:0] c_st_sync  = 4'd6;
  localparam logic [3:0] c_st_tar2  = 4'd7;
  localparam logic [3:0] c_st_done  = 4'd8;

  logic [3:0]          state_q,    state_d;
  logic [3:0]          ctdir_q,    ctdir_d;
  logic [3:0]          size_q,     size_d;
  logic [31:0]         addr_q,     addr_d;
  logic [31:0]         data_q,     data_d;
  logic [2:0]          nib_cnt_q,  nib_cnt_d;
  logic [c_wait_w-1:0] wait_cnt_q, wait_cnt_d;
  logic [3:0]          o_ct_q,     o_ct_d;
  logic [31:0]         o_addr_q,   o_addr_d;
  logic [31:0]         o_data_q,   o_data_d;
  logic [3:0]          o_size_q,   o_size_d;

  logic       w_write;
  logic [2:0] w_addr_last;
  logic [3:0] w_data_last;

  assign w_write     = ctdir_q[1];
  // Memory cycles (type bit 2 set) carry 8 address nibbles, IO cycles 4.
  assign w_addr_last = ctdir_q[2] ? 3'd7 : 3'd3;
  assign w_data_last = {size_q[2:0], 1'b0} - 4'd1;

  always_comb begin
    state_d    = state_q;
    ctdir_d    = ctdir_q;
    size_d     = size_q;
    addr_d     = addr_q;
    data_d     = data_q;
    nib_cnt_d  = nib_cnt_q;
    wait_cnt_d = wait_cnt_q;
    o_ct_d     = o_ct_q;
    o_addr_d   = o_addr_q;
    o_data_d   = o_data_q;
    o_size_d   = o_size_q;

    if (!lpc_frame) begin
      // LFRAME# low overrides everything: abort any partial record and take
      // the current nibble as the START candidate.
      state_d = (lpc_ad == 4'b0000) ? c_st_ctdir : c_st_idle;
    end else begin
      case (state_q)
        c_st_idle, c_st_done: begin
          state_d = c_st_idle;
        end
        c_st_ctdir: begin
          addr_d     = '0;
          data_d     = '0;
          nib_cnt_d  = '0;
          wait_cnt_d = '0;
          ctdir_d    = {lpc_ad[3:1], 1'b0};
          if (lpc_ad[3:2] == 2'b01) begin
            state_d = c_st_size;
          end else if (c_io_en && (lpc_ad[3:2] == 2'b00)) begin
            size_d  = 4'd1;
            state_d = c_st_addr;
          end else begin
            state_d = c_st_idle;
          end
        end
        c_st_size: begin
          case (lpc_ad[1:0])
            2'd1:    size_d = 4'd2;
            2'd3:    size_d = 4'd4;
            default: size_d = 4'd1;
          endcase
          state_d = c_st_addr;
        end
        c_st_addr: begin
          addr_d = {addr_q[27:0], lpc_ad};
          if (nib_cnt_q == w_addr_last) begin
            nib_cnt_d = '0;
            state_d   = w_write ? c_st_data : c_st_tar1;
          end else begin
            nib_cnt_d = nib_cnt_q + 3'd1;
          end
        end
        c_st_data: begin
          data_d[{nib_cnt_q, 2'b00} +: 4] = lpc_ad;
          if ({1'b0, nib_cnt_q} == w_data_last) begin
            nib_cnt_d = '0;
            state_d   = w_write ? c_st_tar1 : c_st_tar2;
          end else begin
            nib_cnt_d = nib_cnt_q + 3'd1;
          end
        end
        c_st_tar1: begin
          if (nib_cnt_q == 3'd1) begin
            nib_cnt_d  = '0;
            wait_cnt_d = '0;
            state_d    = c_st_sync;
          end else begin
            nib_cnt_d = nib_cnt_q + 3'd1;
          end
        end
        c_st_sync: begin
          if (lpc_ad == 4'b0000) begin
            nib_cnt_d = '0;
            state_d   = w_write ? c_st_tar2 : c_st_data;
          end else if ((lpc_ad == 4'b0101) || (lpc_ad == 4'b0110)) begin
            if (wait_cnt_q == c_wait_max) begin
              state_d = c_st_idle;
            end else begin
              wait_cnt_d = wait_cnt_q + 1'b1;
            end
          end else begin
            // Error sync (1010) and any unknown nibble drop the record.
            state_d = c_st_idle;
          end
        end
        c_st_tar2: begin
          if (nib_cnt_q == 3'd1) begin
            nib_cnt_d = '0;
            o_ct_d    = ctdir_q;
            o_addr_d  = addr_q;
            o_data_d  = data_q;
            o_size_d  = size_q;
            state_d   = c_st_done;
          end else begin
            nib_cnt_d = nib_cnt_q + 3'd1;
          end
        end
        default: begin
          state_d = c_st_idle;
        end
      endcase
    end
  end

  always_ff @(posedge lpc_clock) begin
    if (lpc_reset) begin
      state_q    <= c_st_idle;
      ctdir_q    <= '0;
      size_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      nib_cnt_q  <= '0;
      wait_cnt_q <= '0;
      o_ct_q     <= '0;
      o_addr_q   <= '0;
      o_data_q   <= '0;
      o_size_q   <= '0;
    end else begin
      state_q    <= state_d;
      ctdir_q    <= ctdir_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      nib_cnt_q  <= nib_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      o_ct_q     <= o_ct_d;
      o_addr_q   <= o_addr_d;
      o_data_q   <= o_data_d;
      o_size_q   <= o_size_d;
    end
  end

  assign out_cyctype_dir  = o_ct_q;
  assign out_addr         = o_addr_q;
  assign out_data         = o_data_q;
  assign out_data_size    = o_size_q;
  assign out_clock_enable = (state_q == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_lpc_sniffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lpc_sniffer
// Purpose  : Self-checking bench for lpc_sniffer. Drives directed LPC cycles
//            built from transaction descriptions and compares the DUT record
//            outputs against a transaction-level expectation every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lpc_sniffer;

`ifdef LPC_IO_DECODE_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif
  localparam int WAIT_LIMIT = 16;

  logic        clk = 1'b0;
  logic        lpc_reset;
  logic [3:0]  lpc_ad;
  logic        lpc_frame;
  logic [3:0]  out_cyctype_dir;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_data_size;
  logic        out_clock_enable;

  lpc_sniffer #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .lpc_clock        (clk),
    .lpc_reset        (lpc_reset),
    .lpc_ad           (lpc_ad),
    .lpc_frame        (lpc_frame),
    .out_cyctype_dir  (out_cyctype_dir),
    .out_addr         (out_addr),
    .out_data         (out_data),
    .out_data_size    (out_data_size),
    .out_clock_enable (out_clock_enable)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int strobes  = 0;
  bit chk_en   = 1'b0;

  // Record the current transaction will produce, and the copy latched when
  // its final nibble goes onto the bus.
  logic [3:0]  rec_ct,   ld_ct;
  logic [31:0] rec_addr, ld_addr;
  logic [31:0] rec_data, ld_data;
  logic [3:0]  rec_size, ld_size;
  bit          tb_last;

  // Expected DUT outputs.
  logic        exp_strobe = 1'b0;
  logic [3:0]  exp_ct     = '0;
  logic [31:0] exp_addr   = '0;
  logic [31:0] exp_data   = '0;
  logic [3:0]  exp_size   = '0;

  // A record appears, with the strobe, in the cycle after its final TAR
  // nibble; reset clears everything; otherwise outputs hold.
  always @(posedge clk) begin
    if (lpc_reset) begin
      exp_strobe <= 1'b0;
      exp_ct     <= '0;
      exp_addr   <= '0;
      exp_data   <= '0;
      exp_size   <= '0;
    end else begin
      exp_strobe <= tb_last;
      if (tb_last) begin
        exp_ct   <= ld_ct;
        exp_addr <= ld_addr;
        exp_data <= ld_data;
        exp_size <= ld_size;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (out_clock_enable) strobes++;
      if (out_clock_enable !== exp_strobe || out_cyctype_dir !== exp_ct ||
          out_addr !== exp_addr || out_data !== exp_data || out_data_size !== exp_size) begin
        failures++;
        $display("FAIL cycle_compare t=%0t actual: ce=%b ct=%h addr=%h data=%h size=%0d required: ce=%b ct=%h addr=%h data=%h size=%0d",
                 $time, out_clock_enable, out_cyctype_dir, out_addr, out_data, out_data_size,
                 exp_strobe, exp_ct, exp_addr, exp_data, exp_size);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic nib(input logic f, input logic [3:0] d, input bit last);
    @(negedge clk);
    lpc_frame = f;
    lpc_ad    = d;
    tb_last   = last;
    if (last) begin
      ld_ct   = rec_ct;
      ld_addr = rec_addr;
      ld_data = rec_data;
      ld_size = rec_size;
    end
  endtask

  // One LPC cycle from a transaction description. The record is expected
  // only when the type is decoded, the waits stay within the limit and the
  // SYNC terminator is "ready".
  task automatic lpc_cycle(input logic [3:0] ct, input logic [3:0] sz,
                           input logic [31:0] addr, input logic [31:0] data,
                           input int nwait, input logic [3:0] wnib,
                           input logic [3:0] send, input bit gap);
    bit mem, io, wr, decoded, ok;
    int bytes, anib;
    mem     = (ct[3:2] == 2'b01);
    io      = (ct[3:2] == 2'b00);
    wr      = ct[1];
    decoded = mem || (io && IO_EN);
    bytes   = 1;
    if (mem && sz[1:0] == 2'd1) bytes = 2;
    if (mem && sz[1:0] == 2'd3) bytes = 4;
    ok       = decoded && (nwait <= WAIT_LIMIT) && (send == 4'h0);
    rec_ct   = {ct[3:1], 1'b0};
    rec_addr = mem ? addr : {16'h0, addr[15:0]};
    rec_data = '0;
    for (int k = 0; k < 2 * bytes; k++) rec_data[4*k +: 4] = data[4*k +: 4];
    rec_size = bytes[3:0];

    nib(1'b0, 4'h0, 1'b0);
    nib(1'b1, ct, 1'b0);
    if (decoded) begin
      if (mem) nib(1'b1, sz, 1'b0);
      anib = mem ? 8 : 4;
      for (int i = anib - 1; i >= 0; i--) nib(1'b1, addr[4*i +: 4], 1'b0);
      if (wr) for (int k = 0; k < 2 * bytes; k++) nib(1'b1, data[4*k +: 4], 1'b0);
      nib(1'b1, 4'hF, 1'b0);
      nib(1'b1, 4'hF, 1'b0);
      for (int w = 0; w < nwait; w++) nib(1'b1, wnib, 1'b0);
      nib(1'b1, send, 1'b0);
      if (!wr) for (int k = 0; k < 2 * bytes; k++) nib(1'b1, data[4*k +: 4], 1'b0);
      nib(1'b1, 4'hF, 1'b0);
      nib(1'b1, 4'hF, ok);
    end
    if (gap) nib(1'b1, 4'hF, 1'b0);
  endtask

  initial begin
    lpc_reset = 1'b1;
    lpc_frame = 1'b1;
    lpc_ad    = 4'hF;
    tb_last   = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_addr", out_addr, 32'h0);
    chk("reset_ce", {31'h0, out_clock_enable}, 32'h0);
    lpc_reset = 1'b0;
    nib(1'b1, 4'hF, 1'b0);

    // Memory read, 1 byte
    lpc_cycle(4'b0100, 4'h0, 32'hAFFE7FE5, 32'h0000006C, 0, 4'h6, 4'h0, 1'b1);
    chk("memrd_ct", {28'h0, out_cyctype_dir}, 32'h4);
    chk("memrd_addr", out_addr, 32'hAFFE7FE5);
    chk("memrd_data", out_data, 32'h6C);
    chk("memrd_size", {28'h0, out_data_size}, 32'h1);

    // Memory write, 4 bytes
    lpc_cycle(4'b0110, 4'h3, 32'h000F0000, 32'h12345678, 0, 4'h6, 4'h0, 1'b1);
    chk("memwr_ct", {28'h0, out_cyctype_dir}, 32'h6);
    chk("memwr_addr", out_addr, 32'h000F0000);
    chk("memwr_data", out_data, 32'h12345678);
    chk("memwr_size", {28'h0, out_data_size}, 32'h4);

    // Memory read, 2 bytes, three wait nibbles
    lpc_cycle(4'b0100, 4'h1, 32'h12345678, 32'h0000BEEF, 3, 4'h6, 4'h0, 1'b1);
    chk("wait3_data", out_data, 32'hBEEF);

    // SYNC error: record dropped, previous outputs held
    lpc_cycle(4'b0100, 4'h0, 32'h55550000, 32'h00000011, 0, 4'h6, 4'hA, 1'b1);
    chk("syncerr_hold", out_addr, 32'h12345678);

    // Abort mid-address; frame low two cycles, last nibble is the START
    nib(1'b0, 4'h0, 1'b0);
    nib(1'b1, 4'b0100, 1'b0);
    nib(1'b1, 4'h0, 1'b0);
    nib(1'b1, 4'hA, 1'b0);
    nib(1'b1, 4'hB, 1'b0);
    nib(1'b1, 4'hC, 1'b0);
    nib(1'b0, 4'h5, 1'b0);
    lpc_cycle(4'b0110, 4'h0, 32'hCAFE0001, 32'h0000003C, 0, 4'h6, 4'h0, 1'b1);
    chk("abort_addr", out_addr, 32'hCAFE0001);

    // IO read and IO write
    lpc_cycle(4'b0000, 4'h0, 32'h00000080, 32'h0000005A, 0, 4'h6, 4'h0, 1'b1);
    if (IO_EN) chk("ioread_addr", out_addr, 32'h00000080);
    else       chk("io_disabled_hold", out_addr, 32'hCAFE0001);
    lpc_cycle(4'b0010, 4'h0, 32'h000003F8, 32'h000000A5, 1, 4'h5, 4'h0, 1'b1);

    // Wait limit boundary: exactly the limit completes, one more drops
    lpc_cycle(4'b0100, 4'h0, 32'h00001000, 32'h00000042, WAIT_LIMIT, 4'h5, 4'h0, 1'b1);
    chk("waitmax_data", out_data, 32'h42);
    lpc_cycle(4'b0100, 4'h0, 32'h00002000, 32'h00000043, WAIT_LIMIT + 1, 4'h5, 4'h0, 1'b1);

    // Size nibble 2 is treated as one byte
    lpc_cycle(4'b0110, 4'h2, 32'h00003000, 32'h99887766, 0, 4'h6, 4'h0, 1'b1);
    chk("size2_data", out_data, 32'h66);

    // DMA type and a non-zero START nibble: ignored
    lpc_cycle(4'b1000, 4'h0, 32'h0, 32'h0, 0, 4'h6, 4'h0, 1'b1);
    nib(1'b0, 4'h3, 1'b0);
    nib(1'b1, 4'b0100, 1'b0);
    for (int i = 0; i < 12; i++) nib(1'b1, 4'h0, 1'b0);

    // Back-to-back: second START in the DONE cycle
    lpc_cycle(4'b0100, 4'h0, 32'h0000A000, 32'h000000E1, 0, 4'h6, 4'h0, 1'b0);
    lpc_cycle(4'b0110, 4'h1, 32'h0000B000, 32'h0000E2E3, 0, 4'h6, 4'h0, 1'b1);
    chk("b2b_data", out_data, 32'hE2E3);

    // Reset during read data
    nib(1'b0, 4'h0, 1'b0);
    nib(1'b1, 4'b0100, 1'b0);
    nib(1'b1, 4'h0, 1'b0);
    for (int i = 0; i < 8; i++) nib(1'b1, 4'h1, 1'b0);
    nib(1'b1, 4'hF, 1'b0);
    nib(1'b1, 4'hF, 1'b0);
    nib(1'b1, 4'h0, 1'b0);
    nib(1'b1, 4'hD, 1'b0);
    @(negedge clk);
    lpc_reset = 1'b1;
    lpc_ad    = 4'hE;
    @(negedge clk);
    lpc_reset = 1'b0;
    lpc_ad    = 4'hF;
    chk("rst_mid_addr", out_addr, 32'h0);
    chk("rst_mid_data", out_data, 32'h0);
    nib(1'b1, 4'hF, 1'b0);
    nib(1'b1, 4'hF, 1'b0);
    lpc_cycle(4'b0100, 4'h3, 32'hFEDCBA98, 32'h01020304, 0, 4'h6, 4'h0, 1'b1);
    chk("post_rst_data", out_data, 32'h01020304);

    repeat (3) nib(1'b1, 4'hF, 1'b0);
    chk("strobe_count", strobes, IO_EN ? 32'd11 : 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
